// File: rtl/rand_pos_gen_pkg.sv
// Shared types and defaults for the random screen-position generator.
package rand_pos_gen_pkg;

  localparam int H_MAX_DEF = 640;
  localparam int V_MAX_DEF = 480;
  localparam int RND_W     = 5;
  localparam int RAW_W     = 2 * RND_W;
  localparam int CALC_W    = 11;

  typedef enum logic [2:0] {
    S_GET_X0 = 3'd0,
    S_GET_X1 = 3'd1,
    S_GET_Y0 = 3'd2,
    S_GET_Y1 = 3'd3,
    S_REDUCE = 3'd4,
    S_OUT    = 3'd5
  } state_e;

endpackage

// File: rtl/rand_pos_gen_coord_reduce.sv
// Combinational bounded modulo: subtracts the largest multiple k*BOUND
// (k <= STEPS) that does not exceed the input.
module coord_reduce #(
  parameter int CW    = 11,
  parameter int OUT_W = 10,
  parameter int BOUND = 640,
  parameter int STEPS = 1
) (
  input  logic [CW-1:0]    i_val,
  output logic [OUT_W-1:0] o_val
);

  logic [CW-1:0] w_res;
  logic          w_hit;

  // Highest multiple is tried first so a single subtraction lands in range.
  always_comb begin
    w_res = i_val;
    w_hit = 1'b0;
    for (int k = STEPS; k >= 1; k--) begin
      if (!w_hit && (i_val >= CW'(k * BOUND))) begin
        w_res = i_val - CW'(k * BOUND);
        w_hit = 1'b1;
      end
    end
  end

  assign o_val = OUT_W'(w_res);

endmodule

// File: rtl/rand_pos_gen.sv
// Packs four 5-bit LFSR samples into a raw X/Y pair, reduces each into
// screen range, and offers the result on a valid/ready handshake.
module rand_pos_gen
  import rand_pos_gen_pkg::*;
#(
  parameter int H_MAX = H_MAX_DEF,
  parameter int V_MAX = V_MAX_DEF,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RND_W-1:0] rnd_data,
  input  logic             rnd_valid,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [RAW_W-1:0] r_raw_x;
  logic [RAW_W-1:0] r_raw_y;
  logic [X_W-1:0]   r_pos_x;
  logic [Y_W-1:0]   r_pos_y;
  logic [X_W-1:0]   w_x_red;
  logic [Y_W-1:0]   w_y_red;

  coord_reduce #(.CW(CALC_W), .OUT_W(X_W), .BOUND(H_MAX), .STEPS(1)) u_red_x (
    .i_val (CALC_W'(r_raw_x)),
    .o_val (w_x_red)
  );

  coord_reduce #(.CW(CALC_W), .OUT_W(Y_W), .BOUND(V_MAX), .STEPS(2)) u_red_y (
    .i_val (CALC_W'(r_raw_y)),
    .o_val (w_y_red)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_GET_X0: if (rnd_valid) w_state_nxt = S_GET_X1;
      S_GET_X1: if (rnd_valid) w_state_nxt = S_GET_Y0;
      S_GET_Y0: if (rnd_valid) w_state_nxt = S_GET_Y1;
      S_GET_Y1: if (rnd_valid) w_state_nxt = S_REDUCE;
      S_REDUCE: w_state_nxt = S_OUT;
      S_OUT:    if (pos_ready) w_state_nxt = S_GET_X0;
      default:  w_state_nxt = S_GET_X0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GET_X0;
      r_raw_x <= '0;
      r_raw_y <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (rnd_valid) begin
        case (r_state)
          S_GET_X0: r_raw_x[RAW_W-1:RND_W] <= rnd_data;
          S_GET_X1: r_raw_x[RND_W-1:0]     <= rnd_data;
          S_GET_Y0: r_raw_y[RAW_W-1:RND_W] <= rnd_data;
          S_GET_Y1: r_raw_y[RND_W-1:0]     <= rnd_data;
          default: ;
        endcase
      end
      // Outputs load only here, so they stay frozen throughout OUT.
      if (r_state == S_REDUCE) begin
        r_pos_x <= w_x_red;
        r_pos_y <= w_y_red;
      end
    end
  end

  assign pos_valid = (r_state == S_OUT);
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;

endmodule

// File: doc/rand_pos_gen.md
# rand_pos_gen

Converts the 5-bit pseudo-random stream from the LFSR stage into uniformly bounded screen coordinates (x < H_MAX, y < V_MAX) for the VGA drawing path. It sits directly downstream of the LFSR and upstream of the pixel-plotting logic. It packs four 5-bit samples into one raw X/Y pair, reduces each coordinate into range, and presents the result on a valid/ready handshake.

## Interface
- H_MAX, 640: horizontal bound; output x is in 0..H_MAX-1.
- V_MAX, 480: vertical bound; output y is in 0..V_MAX-1.
- X_W, 10: width of pos_x; 2^X_W must be ≥ H_MAX and < 2·H_MAX.
- Y_W, 9: width of pos_y; 2^(Y_W+1) must be < 3·V_MAX.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous and active-high.
- rnd_data  in  5  LFSR output sample.
- rnd_valid  in  1  sample strobe; tie to 1'b1 when the LFSR free-runs.
- pos_valid  out  1  coordinate pair available.
- pos_ready  in  1  consumer accepts the pair.
- pos_x  out  X_W  reduced x coordinate.
- pos_y  out  Y_W  reduced y coordinate.

## Operation
- FSM states:
  - GET_X0: captures rnd_data into raw_x[9:5].
  - GET_X1: captures rnd_data into raw_x[4:0].
  - GET_Y0: captures rnd_data into raw_y[9:5].
  - GET_Y1: captures rnd_data into raw_y[4:0].
  - REDUCE: one-cycle range reduction.
  - OUT: holds the result for the handshake.
- Each GET_* state advances only on a cycle with rnd_valid=1 and stays put otherwise.
- REDUCE always advances to OUT after one cycle.
- In OUT, pos_valid=1. When pos_ready=1 the FSM goes to GET_X0 on the next edge; otherwise it stays in OUT.
- X reduction: x = raw_x ≥ H_MAX ? raw_x − H_MAX : raw_x. One subtraction suffices, since raw_x ≤ 1023 < 2·640.
- Y reduction:
  - y = raw_y − V_MAX if V_MAX ≤ raw_y < 2·V_MAX.
  - y = raw_y − 2·V_MAX if raw_y ≥ 2·V_MAX.
  - y = raw_y otherwise.
  - All arithmetic is unsigned, 11 bits internally, truncated to X_W/Y_W on register load.
- pos_x/pos_y are registered, load at the REDUCE→OUT edge, and are stable for all of OUT.
- Changes to rnd_data while in OUT have no effect on the outputs.
- The output is not strictly uniform (modulo bias); this is acceptable for display effects.

## Timing
- Reset (synchronous, rst=1 at the edge): state=GET_X0, raw_x=raw_y=0, pos_x=0, pos_y=0, pos_valid=0.
- Reset mid-operation discards any partial sample or pending pair. pos_valid is 0 on the first cycle after the reset edge.
- Latency with rnd_valid held high is 5 cycles from entering GET_X0 to pos_valid=1 (4 sample edges plus REDUCE).
- Throughput with pos_ready=1 and rnd_valid=1: one pair per 6 cycles.
- Handshake: a transfer occurs on an edge where pos_valid & pos_ready. pos_valid never drops without a transfer unless rst is asserted.
- pos_valid is a registered output (decoded from the state register); no combinational path from pos_ready to pos_valid.
- rnd_valid=0 during GET_* stalls the FSM without corrupting already captured bits.

## Structure
- Shared package holds:
  - the state enum (GET_X0..OUT);
  - default constants H_MAX_DEF=640, V_MAX_DEF=480, RND_W=5.
- Sub-module `coord_reduce` is the combinational bounded-modulo unit, parameterised by bound and number of subtract steps (1 for X, 2 for Y). It is instantiated twice.
- The remaining RTL (FSM, capture registers, output registers) stays in rand_pos_gen.

## Test plan
- Reset then rnd_valid=1 with samples 0x1F,0x1F,0x1F,0x1F → pos_valid rises 5 cycles later; pos_x=383, pos_y=63.
- Samples 0x0F,0x1F,0x0E,0x00 → pos_x=511, pos_y=448 (no reduction).
- Boundary: samples 0x14,0x00,0x0F,0x00 (raw 640/480) → pos_x=0, pos_y=0. Raw 639/479 → pos_x=639, pos_y=479.
- Backpressure: hold pos_ready=0 for 10 cycles while rnd_data toggles → pos_valid stays 1 and pos_x/pos_y unchanged. Release → one transfer, and the next pair arrives 5 cycles later.
- Stall: drop rnd_valid for 3 cycles between X1 and Y0 samples → result identical to the unstalled case, delayed 3 cycles.
- Reset asserted in GET_Y0, and separately in OUT → next cycle pos_valid=0, pos_x=pos_y=0; the following pair uses only post-reset samples.
- Free-run against the real LFSR (seed 0x0F) for 1000 pairs → every pos_x < 640 and every pos_y < 480.
